// File: rtl/fwd_hazard_sched.sv
// Pipeline hazard scheduler: tracks the EX/MEM/WB register usage and drives ALU operand
// forwarding selects, load-use and MDU stalls, and branch-flush bubbles.
module fwd_hazard_sched #(
    parameter int unsigned MDU_LAT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic [4:0] id_dst,
    input  logic       id_regwrite,
    input  logic       id_memread,
    input  logic       id_mdu_start,
    input  logic       id_mdu_read,
    input  logic       ex_flush,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
    output logic       stall,
    output logic       idex_bubble,
    output logic       flush_ifid,
    output logic       mdu_busy
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } entry_t;

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelMem = 2'b01;
    localparam logic [1:0] SelWb  = 2'b10;

    entry_t           ex_q, ex_d;
    entry_t           mem_q, mem_d;
    entry_t           wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             mh;
    logic             mdu_accept;
    logic             unused_fields;

    // MEM beats WB; a zero source never matches, so $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic use_src,
                                           input entry_t mem, input entry_t wb);
        logic [1:0] sel;
        sel = SelRf;
        if (use_src && src != 5'd0) begin
            if (mem.regwrite && mem.dst == src) begin
                sel = SelMem;
            end else if (wb.regwrite && wb.dst == src) begin
                sel = SelWb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        mdu_busy    = (cnt_q != '0);
        fwd_a_sel   = fwd_sel(ex_q.rs, ex_q.use_rs, mem_q, wb_q);
        fwd_b_sel   = fwd_sel(ex_q.rt, ex_q.use_rt, mem_q, wb_q);
        lu          = ex_q.memread & ex_q.regwrite & (ex_q.dst != 5'd0) &
                      (((ex_q.dst == id_rs) & id_use_rs) | ((ex_q.dst == id_rt) & id_use_rt));
        mh          = mdu_busy & (id_mdu_start | id_mdu_read);
        // A taken branch discards the ID instruction, so it must not also be held.
        stall       = (lu | mh) & ~ex_flush;
        idex_bubble = lu | mh | ex_flush;
        flush_ifid  = ex_flush;
    end

    always_comb begin
        ex_d = '0;
        if (!idex_bubble) begin
            ex_d.valid    = 1'b1;
            ex_d.rs       = id_rs;
            ex_d.rt       = id_rt;
            ex_d.use_rs   = id_use_rs;
            ex_d.use_rt   = id_use_rt;
            ex_d.dst      = id_dst;
            ex_d.regwrite = id_regwrite;
            ex_d.memread  = id_memread;
        end
        mem_d = ex_q;
        wb_d  = mem_q;

        mdu_accept = id_mdu_start & ~stall & ~ex_flush;
        cnt_d      = cnt_q;
        if (mdu_accept) begin
            cnt_d = CNT_W'(MDU_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    // Entries carry the full record; only some fields feed decisions in later stages.
    assign unused_fields = ^{ex_q.valid, mem_q, wb_q};

endmodule
